alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle execute stage wrapped around the combinational 8-bit ALU.
- Accepts one instruction at a time over a valid/ready handshake and reads two operands from an internal register file.
- Drives the ALU operand and opcode inputs from registers, samples the ALU result, and writes it back to the register file.
- Sits directly upstream and downstream of the ALU: it feeds `x_in`/`y_in`/`op_in` and consumes `z_out`.

## Interface
- `WIDTH`, 8, datapath width; matches the ALU.
- `NREGS`, 4, register-file depth; the address width `AW` is clog2(NREGS), 2 by default.
- `clk  in  1`  single clock; all state updates on the rising edge.
- `rst_n  in  1`  reset, asynchronous, active-low.
- `instr_valid_in  in  1`  instruction present.
- `instr_ready_out  out  1`  sequencer can accept an instruction.
- `instr_ld_in  in  1`  1 = load immediate into rd; 0 = ALU operation.
- `instr_op_in  in  2`  ALU opcode: 00 OR, 01 NAND, 10 NOT x, 11 AND.
- `instr_rd_in`, `instr_rs_in`, `instr_rt_in`  in  AW  destination, x-source and y-source register addresses.
- `instr_imm_in  in  WIDTH`  immediate value for loads.
- `alu_x_out`, `alu_y_out`  out  WIDTH  registered ALU operands.
- `alu_op_out  out  2`  registered ALU opcode.
- `alu_z_in  in  WIDTH`  ALU result.
- `wb_valid_out  out  1`  one-cycle pulse: write-back committed.
- `wb_addr_out  out  AW`, `wb_data_out  out  WIDTH`  address and data of the last write-back; held until the next write-back.
- `dbg_addr_in  in  AW`, `dbg_data_out  out  WIDTH`  combinational register-file read port.

## Operation
- States: IDLE, READ, EXEC, WB.
- **IDLE**
  - `instr_ready_out` = 1; it is 0 in every other state.
  - A handshake occurs when `instr_valid_in` & `instr_ready_out` at a clock edge; the sequencer then captures rd, rs, rt and op.
  - If `instr_ld_in` = 1: result_q <= imm and the state goes to WB.
  - Otherwise the state goes to READ.
- **READ**: `alu_x_out` <= reg[rs], `alu_y_out` <= reg[rt], `alu_op_out` <= op; next state EXEC.
- **EXEC**: result_q <= `alu_z_in`; next state WB.
- **WB**
  - reg[rd] <= result_q; `wb_addr_out` <= rd, `wb_data_out` <= result_q, `wb_valid_out` <= 1.
  - Next state IDLE.
  - `wb_valid_out` is 0 in all other cycles.
- Operands are read in READ, so rd == rs or rd == rt reads the old value.
- No hazard exists: the next instruction's READ always follows the previous WB.
- Register file widths: all WIDTH bits, no carry, no sign. Out-of-range addresses cannot occur when NREGS is a power of 2; NREGS is restricted to powers of 2.
- `dbg_data_out` = reg[`dbg_addr_in`], combinational. It shows the written value in the cycle after WB.
- `instr_*` inputs are ignored when no handshake occurs.

## Timing
- Reset (async assert, sync release) clears:
  - state to IDLE;
  - all registers to 0;
  - `alu_x_out`, `alu_y_out`, `alu_op_out`, `wb_addr_out`, `wb_data_out` to 0;
  - `wb_valid_out` to 0.
- `instr_ready_out` is 1 out of reset.
- Reset mid-operation drops the in-flight instruction: no write-back and no `wb_valid_out` pulse.
- ALU operation with the handshake at edge E0:
  - E1: operands are driven.
  - E2: result is sampled.
  - E3: register write and `wb_valid_out` pulse, lasting one cycle.
  - The earliest next handshake is E4; throughput is 1 per 4 cycles.
- Load with the handshake at E0: write and pulse at E1; the earliest next handshake is E2.
- The ALU path (register to `alu_z_in`) must settle within one clock period.

## Configuration
- `ALU_SEQ_ZERO_FLAG_EN` defined:
  - adds output `zero_flag_out` (1 bit), updated in WB to (result_q == 0) and held otherwise;
  - it updates for loads too;
  - reset value is 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset: `rst_n` = 0 → all outputs 0 and `instr_ready_out` = 1. Release, then read every register via dbg → 0x00.
- Loads and OR: load r1 = 0x20, load r2 = 0x0D, then issue OR rd=r3, rs=r1, rt=r2.
  - `wb_valid_out` pulses 3 cycles after the OR handshake.
  - `wb_data_out` = 0x2D, `wb_addr_out` = 3, dbg r3 = 0x2D.
- Opcodes: with r1 = 0x20 and r2 = 0x0D, NAND → 0xFF, NOT x → 0xDF, AND → 0x00.
  - With `ALU_SEQ_ZERO_FLAG_EN`, `zero_flag_out` = 1 only after the AND.
- In-place update: r1 = 0x20, OR rd=r1, rs=r1, rt=r2 (r2 = 0x0D) → r1 = 0x2D. Issue the next OR back-to-back → it reads 0x2D.
- Handshake: hold `instr_valid_in` = 1 continuously.
  - Exactly one accept per 4 cycles for ALU operations, and per 2 cycles for loads.
  - `instr_ready_out` = 0 in READ, EXEC and WB.
- Mid-operation reset: assert `rst_n` during EXEC of an OR targeting r3 (previously 0x55).
  - No `wb_valid_out` pulse; r3 = 0x00 after reset, cleared by reset rather than written.
  - State is IDLE.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
// Bundles the instruction handshake, the ALU operand/result bus, the
// write-back report and the debug read port of alu_sequencer.
//   slave  : seen by the sequencer (accepts instructions, drives the ALU)
//   master : seen by whoever issues instructions and hosts the ALU
// Optional macro ALU_SEQ_ZERO_FLAG_EN adds zero_flag_out.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface alu_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  // instruction handshake
  logic             instr_valid_in;
  logic             instr_ready_out;
  logic             instr_ld_in;
  logic [1:0]       instr_op_in;
  logic [AW-1:0]    instr_rd_in;
  logic [AW-1:0]    instr_rs_in;
  logic [AW-1:0]    instr_rt_in;
  logic [WIDTH-1:0] instr_imm_in;
  // ALU side
  logic [WIDTH-1:0] alu_x_out;
  logic [WIDTH-1:0] alu_y_out;
  logic [1:0]       alu_op_out;
  logic [WIDTH-1:0] alu_z_in;
  // write-back report
  logic             wb_valid_out;
  logic [AW-1:0]    wb_addr_out;
  logic [WIDTH-1:0] wb_data_out;
  // debug read port
  logic [AW-1:0]    dbg_addr_in;
  logic [WIDTH-1:0] dbg_data_out;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic             zero_flag_out;
`endif

  modport slave (
    input  instr_valid_in, instr_ld_in, instr_op_in,
    input  instr_rd_in, instr_rs_in, instr_rt_in, instr_imm_in,
    input  alu_z_in, dbg_addr_in,
    output instr_ready_out, alu_x_out, alu_y_out, alu_op_out,
    output wb_valid_out, wb_addr_out, wb_data_out,
    output dbg_data_out
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , output zero_flag_out
`endif
  );

  modport master (
    output instr_valid_in, instr_ld_in, instr_op_in,
    output instr_rd_in, instr_rs_in, instr_rt_in, instr_imm_in,
    output alu_z_in, dbg_addr_in,
    input  instr_ready_out, alu_x_out, alu_y_out, alu_op_out,
    input  wb_valid_out, wb_addr_out, wb_data_out,
    input  dbg_data_out
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , input zero_flag_out
`endif
  );
endinterface

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle execute stage around a combinational 8-bit ALU. One
// instruction at a time is accepted over valid/ready, operands are read from
// an internal register file, the ALU is fed from registers, its result is
// sampled and written back.
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : alu_sequencer_if.slave (instruction handshake, ALU x/y/op out,
//            ALU z in, write-back report, combinational debug read port)
// Optional macro ALU_SEQ_ZERO_FLAG_EN adds zero_flag_out, updated on every
// write-back (loads included) to (result == 0).
// Latency: ALU op writes back 3 edges after the handshake, a load 1 edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_sequencer #(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input logic           clk,
  input logic           rst_n,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             w_ready;
  logic             w_accept;

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_rs;
  logic [AW-1:0]    r_rt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_aluX;
  logic [WIDTH-1:0] r_aluY;
  logic [1:0]       r_aluOp;
  logic             r_wbValid;
  logic [AW-1:0]    r_wbAddr;
  logic [WIDTH-1:0] r_wbData;

  assign w_accept = bus.instr_valid_in & w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // Loads skip straight to write-back since the result is already known.
  always_comb begin
    w_nextState = r_state;
    w_ready     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (w_accept) w_nextState = bus.instr_ld_in ? S_WB : S_READ;
      end
      S_READ:  w_nextState = S_EXEC;
      S_EXEC:  w_nextState = S_WB;
      S_WB:    w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Operands are read in READ, after the previous write-back has landed,
  // so rd == rs/rt always sees the pre-instruction value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs    <= '{default: '0};
      r_rd      <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_op      <= '0;
      r_result  <= '0;
      r_aluX    <= '0;
      r_aluY    <= '0;
      r_aluOp   <= '0;
      r_wbValid <= 1'b0;
      r_wbAddr  <= '0;
      r_wbData  <= '0;
    end else begin
      r_wbValid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rd <= bus.instr_rd_in;
            r_rs <= bus.instr_rs_in;
            r_rt <= bus.instr_rt_in;
            r_op <= bus.instr_op_in;
            if (bus.instr_ld_in) r_result <= bus.instr_imm_in;
          end
        end
        S_READ: begin
          r_aluX  <= r_regs[r_rs];
          r_aluY  <= r_regs[r_rt];
          r_aluOp <= r_op;
        end
        S_EXEC: r_result <= bus.alu_z_in;
        S_WB: begin
          r_regs[r_rd] <= r_result;
          r_wbValid    <= 1'b1;
          r_wbAddr     <= r_rd;
          r_wbData     <= r_result;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic r_zeroFlag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_zeroFlag <= 1'b0;
    else if (r_state == S_WB) r_zeroFlag <= (r_result == '0);
  end

  assign bus.zero_flag_out = r_zeroFlag;
`endif

  assign bus.instr_ready_out = w_ready;
  assign bus.alu_x_out       = r_aluX;
  assign bus.alu_y_out       = r_aluY;
  assign bus.alu_op_out      = r_aluOp;
  assign bus.wb_valid_out    = r_wbValid;
  assign bus.wb_addr_out     = r_wbAddr;
  assign bus.wb_data_out     = r_wbData;
  assign bus.dbg_data_out    = r_regs[bus.dbg_addr_in];

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
// Drives alu_sequencer through directed scenarios and random instruction
// streams. A transaction-level model (register array plus a pending
// instruction with a countdown to its write-back) predicts every output;
// a negedge process compares the DUT against it every cycle. Directed
// scenarios add hand-computed literal expectations.
// Inputs change 2 ns after the rising edge; outputs are sampled later.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alu_sequencer;
  localparam int WIDTH = 8;
  localparam int NREGS = 4;
  localparam int AW    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_sequencer_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  alu_sequencer #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Opcode meaning: 00 OR, 01 NAND, 10 NOT x, 11 AND.
  function automatic logic [7:0] aluRef(input logic [1:0] op,
                                        input logic [7:0] x,
                                        input logic [7:0] y);
    case (op)
      2'b00:   return x | y;
      2'b01:   return ~(x & y);
      2'b10:   return ~x;
      default: return x & y;
    endcase
  endfunction

  // The ALU the sequencer feeds.
  assign bus.alu_z_in = aluRef(bus.alu_op_out, bus.alu_x_out, bus.alu_y_out);

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [7:0]    mReg [NREGS] = '{default: 8'h00};
  logic          mPend = 1'b0;
  int            mLeft = 0;
  logic          mLd = 1'b0;
  logic [AW-1:0] mRd = '0;
  logic [7:0]    mData = 8'h00;
  logic [7:0]    mX = 8'h00, mY = 8'h00;
  logic [1:0]    mOp = 2'b00;
  logic [7:0]    eX = 8'h00, eY = 8'h00;
  logic [1:0]    eOp = 2'b00;
  logic          eWbValid = 1'b0;
  logic [AW-1:0] eWbAddr = '0;
  logic [7:0]    eWbData = 8'h00;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic          eZero = 1'b0;
`endif

  // An accepted instruction completes after 3 edges (ALU) or 1 edge (load);
  // ALU operands appear after the first edge. Nothing is accepted while busy.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mReg     <= '{default: 8'h00};
      mPend    <= 1'b0;
      mLeft    <= 0;
      eX       <= 8'h00;
      eY       <= 8'h00;
      eOp      <= 2'b00;
      eWbValid <= 1'b0;
      eWbAddr  <= '0;
      eWbData  <= 8'h00;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      eZero    <= 1'b0;
`endif
    end else begin
      eWbValid <= 1'b0;
      if (mPend) begin
        mLeft <= mLeft - 1;
        if (!mLd && mLeft == 3) begin
          eX  <= mX;
          eY  <= mY;
          eOp <= mOp;
        end
        if (mLeft == 1) begin
          mReg[mRd] <= mData;
          eWbValid  <= 1'b1;
          eWbAddr   <= mRd;
          eWbData   <= mData;
`ifdef ALU_SEQ_ZERO_FLAG_EN
          eZero     <= (mData == 8'h00);
`endif
          mPend     <= 1'b0;
        end
      end else if (bus.instr_valid_in) begin
        mPend <= 1'b1;
        mLd   <= bus.instr_ld_in;
        mRd   <= bus.instr_rd_in;
        mX    <= mReg[bus.instr_rs_in];
        mY    <= mReg[bus.instr_rt_in];
        mOp   <= bus.instr_op_in;
        mData <= bus.instr_ld_in ? bus.instr_imm_in
                 : aluRef(bus.instr_op_in, mReg[bus.instr_rs_in], mReg[bus.instr_rt_in]);
        mLeft <= bus.instr_ld_in ? 1 : 3;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  logic compareOn = 1'b1;

  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("ready",   32'(bus.instr_ready_out), 32'(!mPend));
      checkOutput("aluX",    32'(bus.alu_x_out),       32'(eX));
      checkOutput("aluY",    32'(bus.alu_y_out),       32'(eY));
      checkOutput("aluOp",   32'(bus.alu_op_out),      32'(eOp));
      checkOutput("wbValid", 32'(bus.wb_valid_out),    32'(eWbValid));
      checkOutput("wbAddr",  32'(bus.wb_addr_out),     32'(eWbAddr));
      checkOutput("wbData",  32'(bus.wb_data_out),     32'(eWbData));
      checkOutput("dbgData", 32'(bus.dbg_data_out),    32'(mReg[bus.dbg_addr_in]));
`ifdef ALU_SEQ_ZERO_FLAG_EN
      checkOutput("zeroFlag", 32'(bus.zero_flag_out),  32'(eZero));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic nextCycle();
    @(posedge clk);
    #2;
    bus.dbg_addr_in = AW'($urandom_range(0, NREGS - 1));
  endtask

  task automatic scrambleFields();
    bus.instr_ld_in  = 1'($urandom_range(0, 1));
    bus.instr_op_in  = 2'($urandom_range(0, 3));
    bus.instr_rd_in  = AW'($urandom_range(0, NREGS - 1));
    bus.instr_rs_in  = AW'($urandom_range(0, NREGS - 1));
    bus.instr_rt_in  = AW'($urandom_range(0, NREGS - 1));
    bus.instr_imm_in = 8'($urandom_range(0, 255));
  endtask

  // Presents one instruction and returns 2 ns after the accepting edge.
  task automatic applyStimulus(input logic ld, input logic [1:0] op,
                               input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                               input logic [AW-1:0] rt, input logic [7:0] imm);
    logic accepted;
    accepted = 1'b0;
    bus.instr_valid_in = 1'b1;
    bus.instr_ld_in    = ld;
    bus.instr_op_in    = op;
    bus.instr_rd_in    = rd;
    bus.instr_rs_in    = rs;
    bus.instr_rt_in    = rt;
    bus.instr_imm_in   = imm;
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_ready_out === 1'b1) begin
        nextCycle();
        accepted = 1'b1;
        break;
      end
      nextCycle();
    end
    bus.instr_valid_in = 1'b0;
    scrambleFields();
    if (!accepted) checkOutput("handshakeTimeout", 32'd0, 32'd1);
  endtask

  task automatic loadReg(input logic [AW-1:0] rd, input logic [7:0] imm);
    applyStimulus(1'b1, 2'b00, rd, '0, '0, imm);
    nextCycle();
    checkOutput("loadPulse", 32'(bus.wb_valid_out), 32'd1);
    checkOutput("loadData",  32'(bus.wb_data_out),  32'(imm));
  endtask

  task automatic runAlu(input string name, input logic [1:0] op,
                        input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                        input logic [AW-1:0] rt, input logic [7:0] expData);
    applyStimulus(1'b0, op, rd, rs, rt, 8'h00);
    nextCycle();
    nextCycle();
    checkOutput({name, "NoEarlyPulse"}, 32'(bus.wb_valid_out), 32'd0);
    nextCycle();
    checkOutput({name, "Pulse"}, 32'(bus.wb_valid_out), 32'd1);
    checkOutput({name, "Data"},  32'(bus.wb_data_out),  32'(expData));
    checkOutput({name, "Addr"},  32'(bus.wb_addr_out),  32'(rd));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int accepts;
    bus.instr_valid_in = 1'b0;
    bus.dbg_addr_in    = '0;
    scrambleFields();

    // reset values
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rstReady",   32'(bus.instr_ready_out), 32'd1);
    checkOutput("rstWbValid", 32'(bus.wb_valid_out),    32'd0);
    checkOutput("rstAluX",    32'(bus.alu_x_out),       32'd0);
    checkOutput("rstWbData",  32'(bus.wb_data_out),     32'd0);
    rst_n = 1'b1;
    for (int r = 0; r < NREGS; r++) begin
      bus.dbg_addr_in = AW'(r);
      #1;
      checkOutput("rstReg", 32'(bus.dbg_data_out), 32'd0);
    end
    nextCycle();

    // loads and OR
    loadReg(2'd1, 8'h20);
    loadReg(2'd2, 8'h0D);
    runAlu("or", 2'b00, 2'd3, 2'd1, 2'd2, 8'h2D);
    bus.dbg_addr_in = 2'd3;
    #1;
    checkOutput("dbgR3", 32'(bus.dbg_data_out), 32'h2D);
    nextCycle();
    checkOutput("pulseOneCycle", 32'(bus.wb_valid_out), 32'd0);
    checkOutput("wbDataHeld",    32'(bus.wb_data_out),  32'h2D);

    // remaining opcodes
    runAlu("nand", 2'b01, 2'd0, 2'd1, 2'd2, 8'hFF);
    runAlu("notx", 2'b10, 2'd0, 2'd1, 2'd2, 8'hDF);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    checkOutput("zeroAfterNot", 32'(bus.zero_flag_out), 32'd0);
`endif
    runAlu("and",  2'b11, 2'd0, 2'd1, 2'd2, 8'h00);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    checkOutput("zeroAfterAnd", 32'(bus.zero_flag_out), 32'd1);
`endif

    // in-place update, then back-to-back readers of the new value
    runAlu("inPlace",  2'b00, 2'd1, 2'd1, 2'd2, 8'h2D);
    runAlu("backOr",   2'b00, 2'd1, 2'd1, 2'd2, 8'h2D);
    runAlu("backNot",  2'b10, 2'd0, 2'd1, 2'd2, 8'hD2);

    // continuous valid: ALU ops accepted once per 4 edges
    accepts = 0;
    bus.instr_valid_in = 1'b1;
    bus.instr_ld_in = 1'b0; bus.instr_op_in = 2'b00;
    bus.instr_rd_in = 2'd0; bus.instr_rs_in = 2'd1; bus.instr_rt_in = 2'd2;
    for (int i = 0; i < 16; i++) begin
      if (bus.instr_ready_out === 1'b1) accepts++;
      nextCycle();
    end
    bus.instr_valid_in = 1'b0;
    checkOutput("aluAcceptRate", 32'(accepts), 32'd4);
    nextCycle();

    // continuous valid: loads accepted once per 2 edges
    accepts = 0;
    bus.instr_valid_in = 1'b1;
    bus.instr_ld_in = 1'b1; bus.instr_rd_in = 2'd0; bus.instr_imm_in = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      if (bus.instr_ready_out === 1'b1) accepts++;
      nextCycle();
    end
    bus.instr_valid_in = 1'b0;
    checkOutput("loadAcceptRate", 32'(accepts), 32'd4);
    nextCycle();

    // reset during EXEC drops the instruction
    loadReg(2'd3, 8'h55);
    applyStimulus(1'b0, 2'b00, 2'd3, 2'd1, 2'd2, 8'h00);
    nextCycle();
    rst_n = 1'b0;
    bus.dbg_addr_in = 2'd3;
    #1;
    checkOutput("midRstReady",   32'(bus.instr_ready_out), 32'd1);
    checkOutput("midRstWbValid", 32'(bus.wb_valid_out),    32'd0);
    checkOutput("midRstR3",      32'(bus.dbg_data_out),    32'd0);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkOutput("postRstNoPulse", 32'(bus.wb_valid_out), 32'd0);
    end
    bus.dbg_addr_in = 2'd3;
    #1;
    checkOutput("postRstR3", 32'(bus.dbg_data_out), 32'd0);

    // random instruction stream
    for (int n = 0; n < 120; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) nextCycle();
      applyStimulus(($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0,
                    2'($urandom_range(0, 3)),
                    AW'($urandom_range(0, NREGS - 1)),
                    AW'($urandom_range(0, NREGS - 1)),
                    AW'($urandom_range(0, NREGS - 1)),
                    8'($urandom_range(0, 255)));
    end
    repeat (6) nextCycle();

    compareOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
